// File: rtl/gmii_tx_pkg.sv
// Shared definitions for the GMII frame transmitter: FSM state encoding,
// Ethernet header constants and CRC-32 constants.
package gmii_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam int          ETH_HDR_LEN   = 14;
    localparam logic [15:0] VLAN_TPID     = 16'h8100;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/gmii_frame_tx_crc32_d8.sv
// Combinational byte-wide step of the reflected Ethernet CRC-32 (LSB of the
// data byte enters first); the caller owns the CRC register.
module crc32_d8
    import gmii_tx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c >> 1) ^ (CRC32_POLY & {32{c[0] ^ data[i]}});
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_frame_tx.sv
// GMII Ethernet frame transmitter: preamble/SFD, MAC header, streamed payload,
// zero padding, CRC-32 FCS, inter-frame gap and abort. Define GMII_FRAME_TX_VLAN_EN
// to add an 802.1Q tag (vlan_tci port, 18-byte header).
module gmii_frame_tx
    import gmii_tx_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int IFG_BYTES    = 12
) (
    input  logic        gmii_tx_clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [47:0] des_mac,
    input  logic [47:0] src_mac,
    input  logic [15:0] eth_type,
    input  logic [10:0] data_length,
`ifdef GMII_FRAME_TX_VLAN_EN
    input  logic [15:0] vlan_tci,
`endif
    output logic        data_req,
    input  logic [7:0]  data_in,
    input  logic        tx_abort,
    output logic        tx_busy,
    output logic        tx_done,
    output logic [7:0]  gmii_tx_data,
    output logic        gmii_txen,
    output logic        gmii_txer
);

`ifdef GMII_FRAME_TX_VLAN_EN
    localparam int HDR_LEN = ETH_HDR_LEN + 4;
    localparam int MIN_PAD = MIN_PAYLOAD - 4;
`else
    localparam int HDR_LEN = ETH_HDR_LEN;
    localparam int MIN_PAD = MIN_PAYLOAD;
`endif
    localparam int HDR_BITS = HDR_LEN * 8;
    // The single IDLE cycle before a new start supplies the last gap byte.
    localparam int IFG_LAST = IFG_BYTES - 2;

    tx_state_t           state;
    logic [10:0]         cnt;
    logic [10:0]         len;
    logic [HDR_BITS-1:0] hdr;
    logic [31:0]         crc;
    logic [31:0]         crc_next;
    logic [7:0]          tx_byte;
    logic [7:0]          fcs_byte;
    logic                aborted;

    assign data_req = (state == ST_PAYLOAD);

    always_comb begin
        tx_byte = 8'h00;
        case (state)
            ST_HEADER:  tx_byte = hdr[HDR_BITS-1 -: 8];
            ST_PAYLOAD: tx_byte = data_in;
            default:    tx_byte = 8'h00;
        endcase
    end

    always_comb begin
        fcs_byte = 8'h00;
        case (cnt[1:0])
            2'd0:    fcs_byte = ~crc[7:0];
            2'd1:    fcs_byte = ~crc[15:8];
            2'd2:    fcs_byte = ~crc[23:16];
            default: fcs_byte = ~crc[31:24];
        endcase
    end

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (tx_byte),
        .crc_out (crc_next)
    );

    // Outputs are registered from the current state, so the pins lag the FSM by one cycle.
    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            len          <= '0;
            hdr          <= '0;
            crc          <= CRC32_INIT;
            aborted      <= 1'b0;
            tx_busy      <= 1'b0;
            tx_done      <= 1'b0;
            gmii_tx_data <= 8'h00;
            gmii_txen    <= 1'b0;
            gmii_txer    <= 1'b0;
        end else begin
            tx_done      <= 1'b0;
            gmii_txen    <= 1'b0;
            gmii_txer    <= 1'b0;
            gmii_tx_data <= 8'h00;
            case (state)
                ST_IDLE: begin
                    if (tx_start) begin
                        state   <= ST_PREAMBLE;
                        cnt     <= '0;
                        crc     <= CRC32_INIT;
                        aborted <= 1'b0;
                        tx_busy <= 1'b1;
                        len     <= (data_length > 11'(MAX_PAYLOAD)) ? 11'(MAX_PAYLOAD) : data_length;
`ifdef GMII_FRAME_TX_VLAN_EN
                        hdr     <= {des_mac, src_mac, VLAN_TPID, vlan_tci, eth_type};
`else
                        hdr     <= {des_mac, src_mac, eth_type};
`endif
                    end
                end
                ST_PREAMBLE: begin
                    gmii_txen    <= 1'b1;
                    gmii_tx_data <= PREAMBLE_BYTE;
                    if (cnt == 11'(PREAMBLE_LEN - 1)) begin
                        state <= ST_SFD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                ST_SFD: begin
                    gmii_txen    <= 1'b1;
                    gmii_tx_data <= SFD_BYTE;
                    state        <= ST_HEADER;
                end
                ST_HEADER: begin
                    gmii_txen    <= 1'b1;
                    gmii_tx_data <= tx_byte;
                    crc          <= crc_next;
                    hdr          <= hdr << 8;
                    if (cnt == 11'(HDR_LEN - 1)) begin
                        cnt <= '0;
                        if (len != 11'd0)        state <= ST_PAYLOAD;
                        else if (MIN_PAD != 0)   state <= ST_PAD;
                        else                     state <= ST_FCS;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                ST_PAYLOAD, ST_PAD: begin
                    gmii_txen <= 1'b1;
                    if (tx_abort) begin
                        gmii_txer <= 1'b1;
                        aborted   <= 1'b1;
                        state     <= ST_IFG;
                        cnt       <= '0;
                    end else begin
                        gmii_tx_data <= tx_byte;
                        crc          <= crc_next;
                        cnt          <= cnt + 11'd1;
                        // cnt keeps counting through PAD so it tracks total padded payload.
                        if (state == ST_PAYLOAD && cnt == len - 11'd1) begin
                            if (len < 11'(MIN_PAD)) begin
                                state <= ST_PAD;
                            end else begin
                                state <= ST_FCS;
                                cnt   <= '0;
                            end
                        end else if (state == ST_PAD && cnt == 11'(MIN_PAD - 1)) begin
                            state <= ST_FCS;
                            cnt   <= '0;
                        end
                    end
                end
                ST_FCS: begin
                    gmii_txen    <= 1'b1;
                    gmii_tx_data <= fcs_byte;
                    if (cnt == 11'd3) begin
                        state <= ST_IFG;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                ST_IFG: begin
                    tx_done <= (cnt == 11'd0) && !aborted;
                    if (cnt == 11'(IFG_LAST)) begin
                        state   <= ST_IDLE;
                        cnt     <= '0;
                        tx_busy <= 1'b0;
                    end else begin
                        cnt <= cnt + 11'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gmii_frame_tx.sv
// Self-checking bench for gmii_frame_tx: a frame-level reference model feeds a
// scoreboard that a negedge monitor drains whenever a frame appears on GMII.
module tb_gmii_frame_tx;

    localparam int PRE  = 7;
    localparam int MAXP = 1500;
`ifdef GMII_FRAME_TX_VLAN_EN
    localparam int MINP = 42;
`else
    localparam int MINP = 46;
`endif

    logic        gmii_tx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [47:0] des_mac = '0;
    logic [47:0] src_mac = '0;
    logic [15:0] eth_type = '0;
    logic [10:0] data_length = '0;
`ifdef GMII_FRAME_TX_VLAN_EN
    logic [15:0] vlan_tci = '0;
`endif
    logic        data_req;
    logic [7:0]  data_in;
    logic        tx_abort;
    logic        tx_busy;
    logic        tx_done;
    logic [7:0]  gmii_tx_data;
    logic        gmii_txen;
    logic        gmii_txer;

    logic [7:0]  cur_payload [0:2047];
    logic [10:0] pay_idx = '0;
    logic        abort_en = 1'b0;
    logic [10:0] abort_at = '0;

    logic [7:0] exp_byte [$];
    bit         exp_er   [$];
    int         exp_len  [$];
    bit         exp_done [$];
    int         exp_req  [$];
    int         gaps     [$];
    logic [7:0] rx_byte  [$];
    bit         rx_er    [$];

    int checks = 0, errors = 0;
    int frames_exp = 0, frames_rx = 0, done_exp = 0, done_seen = 0;
    bit in_frame = 0, seen_any = 0;
    int gap = 0, req_cnt = 0;

    always #4 gmii_tx_clk = ~gmii_tx_clk;

    gmii_frame_tx dut (
        .gmii_tx_clk  (gmii_tx_clk),
        .rst_n        (rst_n),
        .tx_start     (tx_start),
        .des_mac      (des_mac),
        .src_mac      (src_mac),
        .eth_type     (eth_type),
        .data_length  (data_length),
`ifdef GMII_FRAME_TX_VLAN_EN
        .vlan_tci     (vlan_tci),
`endif
        .data_req     (data_req),
        .data_in      (data_in),
        .tx_abort     (tx_abort),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .gmii_tx_data (gmii_tx_data),
        .gmii_txen    (gmii_txen),
        .gmii_txer    (gmii_txer)
    );

    // Payload source: serves the byte at pay_idx and rewinds whenever the transmitter is idle.
    assign data_in  = cur_payload[pay_idx];
    assign tx_abort = abort_en && data_req && (pay_idx == abort_at);

    always @(posedge gmii_tx_clk) begin
        if (!tx_busy)      pay_idx <= '0;
        else if (data_req) pay_idx <= pay_idx + 11'd1;
    end

    function automatic logic [31:0] crcStep(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference model: whole expected GMII frame built from the frame-format rules.
    task automatic buildExpected(input int dlen, input int abort_idx);
        logic [7:0] body [$];
        logic [31:0] c;
        int len;
        bit ab;
        len = (dlen > MAXP) ? MAXP : dlen;
        ab  = (abort_idx >= 0) && (abort_idx < len);
        for (int i = 5; i >= 0; i--) body.push_back(des_mac[8*i +: 8]);
        for (int i = 5; i >= 0; i--) body.push_back(src_mac[8*i +: 8]);
`ifdef GMII_FRAME_TX_VLAN_EN
        body.push_back(8'h81); body.push_back(8'h00);
        body.push_back(vlan_tci[15:8]); body.push_back(vlan_tci[7:0]);
`endif
        body.push_back(eth_type[15:8]);
        body.push_back(eth_type[7:0]);
        for (int i = 0; i < PRE; i++) begin exp_byte.push_back(8'h55); exp_er.push_back(1'b0); end
        exp_byte.push_back(8'hD5); exp_er.push_back(1'b0);
        if (ab) begin
            for (int i = 0; i < abort_idx; i++) body.push_back(cur_payload[i]);
            foreach (body[i]) begin exp_byte.push_back(body[i]); exp_er.push_back(1'b0); end
            exp_byte.push_back(8'h00); exp_er.push_back(1'b1);
            exp_len.push_back(PRE + 1 + body.size() + 1);
            exp_req.push_back(abort_idx + 1);
            exp_done.push_back(1'b0);
        end else begin
            for (int i = 0; i < len; i++) body.push_back(cur_payload[i]);
            for (int i = len; i < MINP; i++) body.push_back(8'h00);
            c = 32'hFFFFFFFF;
            foreach (body[i]) c = crcStep(c, body[i]);
            c = ~c;
            for (int i = 0; i < 4; i++) body.push_back(c[8*i +: 8]);
            foreach (body[i]) begin exp_byte.push_back(body[i]); exp_er.push_back(1'b0); end
            exp_len.push_back(PRE + 1 + body.size());
            exp_req.push_back(len);
            exp_done.push_back(1'b1);
            done_exp++;
        end
        frames_exp++;
    endtask

    task automatic randomFields(input int dlen, input bit ramp);
        logic [63:0] r;
        r = {$urandom(), $urandom()}; des_mac = r[47:0];
        r = {$urandom(), $urandom()}; src_mac = r[47:0];
        eth_type = 16'($urandom());
`ifdef GMII_FRAME_TX_VLAN_EN
        vlan_tci = 16'($urandom());
`endif
        data_length = 11'(dlen);
        for (int i = 0; i < 2048; i++) cur_payload[i] = ramp ? 8'(i) : 8'($urandom());
    endtask

    task automatic applyStimulus(input int dlen, input int abort_idx, input bit ramp);
        int n;
        n = 0;
        @(negedge gmii_tx_clk);
        while (tx_busy && n < 4000) begin @(negedge gmii_tx_clk); n++; end
        if (tx_busy) checkOutput("busy_timeout", 32'd1, 32'd0);
        randomFields(dlen, ramp);
        abort_en = (abort_idx >= 0);
        abort_at = 11'(abort_idx < 0 ? 0 : abort_idx);
        buildExpected(dlen, abort_idx);
        tx_start = 1'b1;
        @(negedge gmii_tx_clk);
        tx_start = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((frames_rx < frames_exp || tx_busy) && n < 5000) begin @(negedge gmii_tx_clk); n++; end
        if (frames_rx < frames_exp || tx_busy) checkOutput("drain_timeout", 32'(frames_rx), 32'(frames_exp));
    endtask

    task automatic compareFrame();
        int n, req, bad_b, bad_e;
        bit d;
        logic [7:0] eb;
        bit ee;
        logic [31:0] c;
        if (exp_len.size() == 0) begin
            checkOutput("unexpected_frame", 32'(rx_byte.size()), 32'd0);
            return;
        end
        n = exp_len.pop_front(); req = exp_req.pop_front(); d = exp_done.pop_front();
        bad_b = 0; bad_e = 0;
        checkOutput("frame_len", 32'(rx_byte.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            eb = exp_byte.pop_front(); ee = exp_er.pop_front();
            if (i >= rx_byte.size() || rx_byte[i] !== eb) bad_b++;
            if (i >= rx_er.size() || rx_er[i] !== ee) bad_e++;
        end
        checkOutput("frame_byte_errs", 32'(bad_b), 32'd0);
        checkOutput("frame_txer_errs", 32'(bad_e), 32'd0);
        checkOutput("data_req_cycles", 32'(req_cnt), 32'(req));
        checkOutput("tx_done_pulse", {31'd0, tx_done}, {31'd0, d});
        if (d && rx_byte.size() > PRE + 1) begin
            c = 32'hFFFFFFFF;
            for (int i = PRE + 1; i < rx_byte.size(); i++) c = crcStep(c, rx_byte[i]);
            checkOutput("fcs_residue", c, 32'hDEBB20E3);
        end
        frames_rx++;
    endtask

    // Monitor: collects each txen burst and scores it against the model queue.
    always @(negedge gmii_tx_clk) begin
        if (!rst_n) begin
            in_frame = 0; seen_any = 0; gap = 0; req_cnt = 0;
            rx_byte.delete(); rx_er.delete();
        end else begin
            if (tx_done) done_seen++;
            if (gmii_txen) begin
                if (!in_frame) begin
                    if (seen_any) begin
                        gaps.push_back(gap);
                        checkOutput("ifg_min", {31'd0, gap >= 12}, 32'd1);
                    end
                    in_frame = 1; req_cnt = 0;
                    rx_byte.delete(); rx_er.delete();
                end
                rx_byte.push_back(gmii_tx_data);
                rx_er.push_back(gmii_txer);
                if (data_req) req_cnt++;
            end else begin
                if (gmii_txer) checkOutput("txer_idle", 32'd1, 32'd0);
                if (in_frame) begin
                    compareFrame();
                    in_frame = 0; seen_any = 1; gap = 1;
                end else begin
                    gap++;
                end
            end
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge gmii_tx_clk);
        checkOutput("rst_txen", {31'd0, gmii_txen}, 32'd0);
        checkOutput("rst_txer", {31'd0, gmii_txer}, 32'd0);
        checkOutput("rst_data", {24'd0, gmii_tx_data}, 32'd0);
        checkOutput("rst_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("rst_done", {31'd0, tx_done}, 32'd0);
        checkOutput("rst_data_req", {31'd0, data_req}, 32'd0);
        rst_n = 1'b1;

        applyStimulus(64, -1, 1'b1);
        applyStimulus(0, -1, 1'b0);
        applyStimulus(MINP - 1, -1, 1'b0);
        applyStimulus(MINP, -1, 1'b0);
        applyStimulus(MINP + 1, -1, 1'b0);
        applyStimulus(1, -1, 1'b0);
        applyStimulus(30, 9, 1'b0);
        applyStimulus(5, 0, 1'b0);
        applyStimulus(80, 79, 1'b0);
        for (int i = 0; i < 6; i++) begin
            n = $urandom_range(0, 200);
            applyStimulus(n, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 200)) : -1, 1'b0);
        end
        waitDrain();

        // tx_start held high: three frames must come out with minimum spacing.
        @(negedge gmii_tx_clk);
        gaps.delete();
        randomFields(20, 1'b0);
        abort_en = 1'b0;
        for (int i = 0; i < 3; i++) buildExpected(20, -1);
        tx_start = 1'b1;
        n = 0;
        while (frames_rx < frames_exp && n < 2000) begin @(negedge gmii_tx_clk); #1; n++; end
        tx_start = 1'b0;
        if (gaps.size() >= 3) begin
            checkOutput("b2b_gap_2", 32'(gaps[1]), 32'd12);
            checkOutput("b2b_gap_3", 32'(gaps[2]), 32'd12);
        end else begin
            checkOutput("b2b_gap_count", 32'(gaps.size()), 32'd3);
        end
        waitDrain();

        applyStimulus(2000, -1, 1'b0);
        waitDrain();

        // Reset in the middle of a payload kills the frame at once.
        applyStimulus(100, -1, 1'b0);
        n = 0;
        while (!data_req && n < 200) begin @(negedge gmii_tx_clk); n++; end
        checkOutput("reach_payload", {31'd0, data_req}, 32'd1);
        @(negedge gmii_tx_clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midrst_txen", {31'd0, gmii_txen}, 32'd0);
        checkOutput("midrst_txer", {31'd0, gmii_txer}, 32'd0);
        checkOutput("midrst_data", {24'd0, gmii_tx_data}, 32'd0);
        checkOutput("midrst_busy", {31'd0, tx_busy}, 32'd0);
        checkOutput("midrst_done", {31'd0, tx_done}, 32'd0);
        exp_byte.delete(); exp_er.delete(); exp_len.delete(); exp_req.delete(); exp_done.delete();
        frames_exp = frames_rx;
        done_exp--;
        repeat (2) @(negedge gmii_tx_clk);
        rst_n = 1'b1;
        applyStimulus(50, -1, 1'b0);
        waitDrain();

        repeat (5) @(negedge gmii_tx_clk);
        checkOutput("done_pulses", 32'(done_seen), 32'(done_exp));
        checkOutput("frames_left", 32'(exp_len.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
